// File: rtl/pwm_capture.sv
// PWM duty/period capture: synchronizes pwm_in, measures high time and period between rising
// edges, and computes duty = floor(high*256/period) with an 8-step restoring divider.
module pwm_capture #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 pwm_in,
    output logic [7:0]           duty_cycle,
    output logic [CNT_WIDTH-1:0] high_cycles,
    output logic [CNT_WIDTH-1:0] period_cycles,
    output logic                 valid,
    output logic                 stuck
);

    localparam logic [CNT_WIDTH-1:0] TimeoutVal = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StWaitEdge, StMeasure} state_e;

    state_e               state_q;
    logic                 sync1_q;
    logic                 level_q;
    logic                 level_prev_q;
    logic [CNT_WIDTH-1:0] per_cnt_q;
    logic [CNT_WIDTH-1:0] high_cnt_q;

    logic                 div_busy_q;
    logic [2:0]           div_iter_q;
    logic [CNT_WIDTH-1:0] div_rem_q;
    logic [7:0]           div_quo_q;
    logic [CNT_WIDTH-1:0] div_per_q;
    logic [CNT_WIDTH-1:0] div_high_q;

    logic                 rise;
    logic                 timeout_hit;
    logic                 div_done;
    logic [CNT_WIDTH:0]   rem_shift;
    logic                 rem_ge;
    logic [CNT_WIDTH-1:0] rem_next;
    logic [7:0]           quo_next;

    always_comb begin
        rise        = level_q & ~level_prev_q;
        // Once stuck, the counter parks at TIMEOUT and no further timeout pulse is issued.
        timeout_hit = (per_cnt_q == TimeoutVal) && !stuck;
        div_done    = div_busy_q && (div_iter_q == 3'd7);
        rem_shift   = {div_rem_q, 1'b0};
        rem_ge      = rem_shift >= {1'b0, div_per_q};
        rem_next    = rem_shift[CNT_WIDTH-1:0];
        if (rem_ge) begin
            rem_next = CNT_WIDTH'(rem_shift - {1'b0, div_per_q});
        end
        quo_next    = {div_quo_q[6:0], rem_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            sync1_q       <= 1'b0;
            level_q       <= 1'b0;
            level_prev_q  <= 1'b0;
            per_cnt_q     <= '0;
            high_cnt_q    <= '0;
            div_busy_q    <= 1'b0;
            div_iter_q    <= '0;
            div_rem_q     <= '0;
            div_quo_q     <= '0;
            div_per_q     <= '0;
            div_high_q    <= '0;
            duty_cycle    <= '0;
            high_cycles   <= '0;
            period_cycles <= '0;
            valid         <= 1'b0;
            stuck         <= 1'b0;
        end else begin
            sync1_q      <= pwm_in;
            level_q      <= sync1_q;
            level_prev_q <= level_q;
            valid        <= 1'b0;

            if (!enable) begin
                state_q    <= StIdle;
                per_cnt_q  <= '0;
                high_cnt_q <= '0;
                div_busy_q <= 1'b0;
            end else begin
                if (div_busy_q) begin
                    div_rem_q  <= rem_next;
                    div_quo_q  <= quo_next;
                    div_iter_q <= div_iter_q + 3'd1;
                    if (div_done) begin
                        duty_cycle    <= quo_next;
                        high_cycles   <= div_high_q;
                        period_cycles <= div_per_q;
                        valid         <= 1'b1;
                        stuck         <= 1'b0;
                        div_busy_q    <= 1'b0;
                    end
                end

                unique case (state_q)
                    StIdle: begin
                        state_q <= StWaitEdge;
                    end
                    StWaitEdge, StMeasure: begin
                        if (rise) begin
                            state_q    <= StMeasure;
                            per_cnt_q  <= CntOne;
                            high_cnt_q <= CntOne;
                            // The first edge after WAIT_EDGE only arms the counters.
                            if (state_q == StMeasure && !div_busy_q) begin
                                div_per_q  <= per_cnt_q;
                                div_high_q <= high_cnt_q;
                                div_rem_q  <= high_cnt_q;
                                div_quo_q  <= '0;
                                div_iter_q <= '0;
                                div_busy_q <= 1'b1;
                            end
                        end else if (timeout_hit && !div_done) begin
                            state_q       <= StWaitEdge;
                            high_cnt_q    <= '0;
                            duty_cycle    <= level_q ? 8'hFF : 8'h00;
                            high_cycles   <= '0;
                            period_cycles <= '0;
                            valid         <= 1'b1;
                            stuck         <= 1'b1;
                        end else if (per_cnt_q != TimeoutVal) begin
                            per_cnt_q <= per_cnt_q + CntOne;
                            if (state_q == StMeasure && level_q) begin
                                high_cnt_q <= high_cnt_q + CntOne;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, as the width of the period and high-time counters.
REQ-002 SHALL have parameter TIMEOUT, default 65535, as the number of cycles without a rising edge before the input is declared stuck; legal range 16 to 2^CNT_WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: capture enable.
REQ-006 SHALL have port pwm_in, input, 1 bit: PWM signal, asynchronous to clk.
REQ-007 SHALL have port duty_cycle, output, 8 bits: measured duty, 0 to 255 scale.
REQ-008 SHALL have port high_cycles, output, CNT_WIDTH bits: measured high time in clk cycles.
REQ-009 SHALL have port period_cycles, output, CNT_WIDTH bits: measured period in clk cycles.
REQ-010 SHALL have port valid, output, 1 bit: one-cycle pulse when outputs update.
REQ-011 SHALL have port stuck, output, 1 bit: level flag, set when no rising edge occurs within TIMEOUT cycles.

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer; "level" below means the second flop output.
REQ-013 SHALL define the edge cycle E as the first cycle in which level=1 after a cycle in which level=0.
REQ-014 SHALL implement states IDLE, WAIT_EDGE and MEASURE, and an independent DIV busy flag.
REQ-015 SHALL move IDLE->WAIT_EDGE when enable=1, and shall move any state->IDLE in the cycle after enable=0, clearing both counters and holding all outputs.
REQ-016 SHALL move WAIT_EDGE->MEASURE on E, loading period counter=1 and high counter=1; this first edge produces no valid.
REQ-017 In MEASURE, every non-edge cycle SHALL increment the period counter, and shall increment the high counter when level=1.
REQ-018 On E in MEASURE with the divider idle, the block SHALL latch period=counter and high=high counter, start the divider, and reload both counters to 1.
REQ-019 On E in MEASURE with the divider busy, the measurement SHALL be discarded, the counters reloaded to 1, and no valid produced.
REQ-020 The divider SHALL be restoring with 8 iterations in cycles E+1..E+8, computing duty=floor(high*256/period); since high<period, the result is 255 maximum and no saturation logic is needed.
REQ-021 In cycle E+9, valid SHALL equal 1; duty_cycle, high_cycles and period_cycles SHALL update in that same cycle; stuck SHALL clear; DIV busy SHALL clear.
REQ-022 If the period counter reaches TIMEOUT in WAIT_EDGE or MEASURE, the block SHALL set stuck=1 and set duty_cycle=255 if level=1, else 0.
REQ-023 On that timeout, the block SHALL also set high_cycles=0 and period_cycles=0, pulse valid once, and go to WAIT_EDGE; no further valid shall occur until a measurement completes.
REQ-024 If timeout and divider completion coincide, the divider result SHALL win and the timeout SHALL be re-evaluated from the reloaded counter.
REQ-025 Counters SHALL never wrap: the timeout check precedes the increment.
REQ-026 Minimum measurable period SHALL be 2 cycles; shorter pulses lost by the synchronizer are not required to be reported.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL clear the synchronizer flops, both counters, all latched values, the divider and the DIV busy flag, and enter IDLE.
REQ-028 When rst=1 at a clock edge, the block SHALL drive duty_cycle=0, high_cycles=0, period_cycles=0, valid=0 and stuck=0.
REQ-029 rst SHALL take priority over enable and over all in-flight operations; a divide in progress SHALL be abandoned with no valid.

Verification
REQ-030 Period 100, high 25, enable=1 -> after the second rising edge, valid pulses every 100 cycles with duty_cycle=64, high_cycles=25, period_cycles=100, stuck=0.
REQ-031 Period 8, high 2 -> the divider is busy at the next edge, so valid pulses every 16 cycles with duty_cycle=64, period_cycles=8.
REQ-032 pwm_in held 0, TIMEOUT=100 -> exactly one valid, stuck=1 and duty_cycle=0, period_cycles=0; then a 50% period-20 signal -> stuck=0 and duty_cycle=128.
REQ-033 pwm_in held 1 after one rising edge, TIMEOUT=100 -> valid with duty_cycle=255 and stuck=1.
REQ-034 Assert rst at E+4 of a measurement -> no valid; the next cycle shows all outputs 0; capture restarts and requires two edges before the next valid.
REQ-035 Drop enable mid-period for 10 cycles -> outputs hold; after re-enable, the first edge produces no valid and the second edge produces a correct valid.
